// File: rtl/k_means_apb_loader.sv
// k_means_apb_loader
//   APB master that feeds the k-means accelerator. It takes data-point words
//   from a valid/ready stream and writes each one into the point RAM as
//   RAM_ADDR, RAM_DATA, RAM_CMD. After the last point it writes CTRL (Go).
//   It then polls STATUS until bit0 is set, and finally pulses done with the
//   last status word.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, num_points  job request (sampled in IDLE) and number of points
//   s_valid/s_data     point word stream in, s_ready out (high only in GET)
//   paddr, pwrite,     APB master request
//   psel, penable,
//   pwdata
//   prdata, pready     APB slave response
//   busy               high from the cycle after start acceptance until done
//   done               one-cycle completion pulse
//   status             last STATUS word read, held until the next start
module k_means_apb_loader #(
  parameter int unsigned          addrWidth    = 8,
  parameter int unsigned          dataWidth    = 32,
  parameter int unsigned          cntWidth     = 8,
  parameter logic [addrWidth-1:0] REG_RAM_ADDR = 8'h00,
  parameter logic [addrWidth-1:0] REG_RAM_DATA = 8'h04,
  parameter logic [addrWidth-1:0] REG_RAM_CMD  = 8'h08,
  parameter logic [addrWidth-1:0] REG_CTRL     = 8'h0C,
  parameter logic [addrWidth-1:0] REG_STATUS   = 8'h10,
  parameter int unsigned          POLL_GAP     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cntWidth-1:0]  num_points,
  input  logic                 s_valid,
  input  logic [dataWidth-1:0] s_data,
  output logic                 s_ready,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  output logic                 busy,
  output logic                 done,
  output logic [dataWidth-1:0] status
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET,
    ST_W_ADDR,
    ST_W_DATA,
    ST_W_CMD,
    ST_GO,
    ST_POLL,
    ST_WAIT,
    ST_FIN
  } state_t;

  state_t               state;
  logic [cntWidth-1:0]  cnt;
  logic [cntWidth-1:0]  index;
  logic [dataWidth-1:0] word;
  logic [GAP_W-1:0]     gap_cnt;

  // An APB transfer completes on the edge where the access phase meets pready.
  logic xfer_done_c;
  assign xfer_done_c = psel && penable && pready;

  // Job sequencer and APB master. Every output is a register.
  // The next transfer's SETUP is loaded on the completion edge of the
  // current one, so chained register writes run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      index   <= '0;
      word    <= '0;
      gap_cnt <= '0;
      s_ready <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwdata  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      status  <= '0;
    end else begin
      done <= 1'b0;

      // The first cycle of any transfer state is SETUP. It moves to ACCESS
      // after that and holds there until the slave is ready.
      if (psel && !penable) begin
        penable <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= num_points;
            index  <= '0;
            status <= '0;
            busy   <= 1'b1;
            if (num_points == '0) begin
              state  <= ST_GO;
              psel   <= 1'b1;
              pwrite <= 1'b1;
              paddr  <= REG_CTRL;
              pwdata <= dataWidth'(1);
            end else begin
              state   <= ST_GET;
              s_ready <= 1'b1;
            end
          end
        end

        ST_GET: begin
          if (s_valid && s_ready) begin
            word    <= s_data;
            s_ready <= 1'b0;
            state   <= ST_W_ADDR;
            psel    <= 1'b1;
            pwrite  <= 1'b1;
            paddr   <= REG_RAM_ADDR;
            pwdata  <= dataWidth'(index);
          end
        end

        ST_W_ADDR: begin
          if (xfer_done_c) begin
            penable <= 1'b0;
            paddr   <= REG_RAM_DATA;
            pwdata  <= word;
            state   <= ST_W_DATA;
          end
        end

        ST_W_DATA: begin
          if (xfer_done_c) begin
            penable <= 1'b0;
            paddr   <= REG_RAM_CMD;
            pwdata  <= dataWidth'(1);
            state   <= ST_W_CMD;
          end
        end

        ST_W_CMD: begin
          if (xfer_done_c) begin
            penable <= 1'b0;
            index   <= index + cntWidth'(1);
            if (cntWidth'(index + cntWidth'(1)) == cnt) begin
              state  <= ST_GO;
              paddr  <= REG_CTRL;
              pwdata <= dataWidth'(1);
            end else begin
              // Bus goes idle while the stream is waited on.
              state   <= ST_GET;
              s_ready <= 1'b1;
              psel    <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= '0;
              pwdata  <= '0;
            end
          end
        end

        ST_GO: begin
          if (xfer_done_c) begin
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= REG_STATUS;
            pwdata  <= '0;
            state   <= ST_POLL;
          end
        end

        ST_POLL: begin
          if (xfer_done_c) begin
            penable <= 1'b0;
            psel    <= 1'b0;
            paddr   <= '0;
            status  <= prdata;
            if (prdata[0]) begin
              state <= ST_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= ST_WAIT;
              gap_cnt <= '0;
            end
          end
        end

        // Counting 0..POLL_GAP leaves POLL_GAP+1 idle bus cycles between reads.
        ST_WAIT: begin
          if (gap_cnt == GAP_W'(POLL_GAP)) begin
            state  <= ST_POLL;
            psel   <= 1'b1;
            pwrite <= 1'b0;
            paddr  <= REG_STATUS;
            pwdata <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // start is not sampled here. A new job has to come from IDLE.
        ST_FIN: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
